// File: rtl/mioc_flop_pkg.sv
// Shared definitions for the MIOC flop bank: edge polarity codes, synchroniser
// depth bounds, the per-channel event bundle and the flop update rule.
package mioc_flop_pkg;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CHANNELS_MIN    = 1;
  localparam int CHANNELS_MAX    = 32;

  // Wide enough to hold SYNC_STAGES_MAX in the arm counter.
  localparam int ARM_W = $clog2(SYNC_STAGES_MAX + 1);

  typedef struct packed {
    logic clr;
    logic set;
    logic tgl;
  } chan_ev_t;

  // Clear beats set, set beats toggle; no event holds the current value.
  function automatic logic flop_next(input chan_ev_t ev, input logic q_cur);
    if (ev.clr)      return 1'b0;
    else if (ev.set) return 1'b1;
    else if (ev.tgl) return ~q_cur;
    else             return q_cur;
  endfunction

endpackage

// File: rtl/mioc_edge_sync.sv
// One-bit synchroniser with a previous-value register and a single-polarity
// edge detector. While not armed (or in reset) the whole chain tracks the raw pin.
module mioc_edge_sync
  import mioc_flop_pkg::*;
#(
  parameter int   STAGES = 2,
  parameter logic EDGE   = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  input  logic arm_i,
  output logic ev_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              sync_out;
  logic              rise;
  logic              fall;

  // Flushing every stage to the raw level means a change seen while disarmed
  // can never surface later as an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst || !arm_i) begin
      sync_q <= {STAGES{din_i}};
      prev_q <= din_i;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;
  assign ev_o     = arm_i & ((EDGE == EDGE_FALL) ? fall : rise);

endmodule

// File: rtl/mioc_flop_bank.sv
// Bank of CHANNELS synchronised set/clear/toggle flops with change strobes.
// Define MIOC_FLOP_CONFLICT_EN to build the sticky set/clear conflict flags.
module mioc_flop_bank
  import mioc_flop_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] SET_EDGE    = '0,
  parameter logic [CHANNELS-1:0] CLR_EDGE    = '0,
  parameter logic [CHANNELS-1:0] Q_INIT      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] set_in,
  input  logic [CHANNELS-1:0] clr_in,
  input  logic [CHANNELS-1:0] tgl_in,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qbar,
  output logic [CHANNELS-1:0] q_chg,
  output logic [CHANNELS-1:0] conflict,
  input  logic [CHANNELS-1:0] conflict_clr
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("mioc_flop_bank: SYNC_STAGES must be in 2..4");
  end
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("mioc_flop_bank: CHANNELS must be in 1..32");
  end

  logic [ARM_W-1:0]    arm_q;
  logic                armed;
  logic [CHANNELS-1:0] clr_ev;
  logic [CHANNELS-1:0] set_ev;
  logic [CHANNELS-1:0] tgl_ev;
  logic [CHANNELS-1:0] q_q;
  logic [CHANNELS-1:0] q_d;
  logic [CHANNELS-1:0] chg_q;
  logic [CHANNELS-1:0] chg_d;

  assign armed = (arm_q == '0);

  // Holds edge detection off for SYNC_STAGES cycles after reset.
  always_ff @(posedge clk) begin
    if (rst)         arm_q <= ARM_W'(SYNC_STAGES);
    else if (!armed) arm_q <= arm_q - ARM_W'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    mioc_edge_sync #(.STAGES(SYNC_STAGES), .EDGE(CLR_EDGE[i])) u_clr (
      .clk(clk), .rst(rst), .din_i(clr_in[i]), .arm_i(armed), .ev_o(clr_ev[i])
    );
    mioc_edge_sync #(.STAGES(SYNC_STAGES), .EDGE(SET_EDGE[i])) u_set (
      .clk(clk), .rst(rst), .din_i(set_in[i]), .arm_i(armed), .ev_o(set_ev[i])
    );
    mioc_edge_sync #(.STAGES(SYNC_STAGES), .EDGE(EDGE_RISE)) u_tgl (
      .clk(clk), .rst(rst), .din_i(tgl_in[i]), .arm_i(armed), .ev_o(tgl_ev[i])
    );
  end

  always_comb begin
    chan_ev_t ev;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    ev  = '0;
    q_d = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      ev     = '{clr: clr_ev[i], set: set_ev[i], tgl: tgl_ev[i]};
      q_d[i] = flop_next(ev, q_q[i]);
    end
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= Q_INIT;
      chg_q <= '0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q     = q_q;
  assign qbar  = ~q_q;
  assign q_chg = chg_q;

`ifdef MIOC_FLOP_CONFLICT_EN
  logic [CHANNELS-1:0] conflict_q;
  logic [CHANNELS-1:0] conflict_d;

  // A fresh conflict outranks a same-cycle write-one-to-clear.
  assign conflict_d = (conflict_q & ~conflict_clr) | (clr_ev & set_ev);

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= '0;
    else     conflict_q <= conflict_d;
  end

  assign conflict = conflict_q;
`else
  logic unused_conflict_clr;

  assign unused_conflict_clr = ^conflict_clr;
  assign conflict            = '0;
`endif

endmodule

// File: doc/mioc_flop_bank.md
Name: mioc_flop_bank

Overview:
- Parametrised, clocked successor to the MIOC open-drain set/reset flop: CHANNELS independent set/clear/toggle flops in one bank.
- Each channel's asynchronous set, clear and toggle inputs are synchronised to clk and edge-detected, with per-channel selectable edge polarity.
- Flops update with fixed priority, giving complementary q/qbar and a one-cycle change strobe.
- Sits between raw MIOC control pins and the synchronous control logic; replaces per-flop transistor-level instances.

Parameters:
- CHANNELS, 4, number of flop channels (1..32).
- SYNC_STAGES, 2, synchroniser depth per input (2..4).
- SET_EDGE, {CHANNELS{1'b0}}, per-channel set trigger: 0 = rising edge, 1 = falling edge.
- CLR_EDGE, {CHANNELS{1'b0}}, per-channel clear trigger: 0 = rising edge, 1 = falling edge.
- Q_INIT, {CHANNELS{1'b0}}, per-channel q value loaded by rst.

Ports:
- clk, input, 1, single clock; all state on its rising edge.
- rst, input, 1, synchronous active-high reset.
- set_in, input, CHANNELS, asynchronous set request per channel.
- clr_in, input, CHANNELS, asynchronous clear request per channel.
- tgl_in, input, CHANNELS, asynchronous toggle request per channel; rising edge only.
- q, output, CHANNELS, flop state.
- qbar, output, CHANNELS, always ~q.
- q_chg, output, CHANNELS, one-cycle strobe when q changes value.
- conflict, output, CHANNELS, sticky same-cycle set/clear conflict flag (see Optional Feature).
- conflict_clr, input, CHANNELS, write-one-to-clear for conflict.

Behaviour:
- Reset: synchronous, active-high. While rst is sampled high:
  - q = Q_INIT, qbar = ~Q_INIT, q_chg = 0, conflict = 0.
  - All synchroniser stages and previous-value registers load the current raw input.
  - Arm counter loads SYNC_STAGES.
- Arming: after rst deasserts, edge detection is masked until the arm counter decrements to 0 (SYNC_STAGES cycles). Any input edge inside that window is ignored; no spurious edge may come from pipeline fill.
- Sync/edge path: per input, SYNC_STAGES flops, then a prev register.
  - Rising edge = sync_out & ~prev; falling edge = ~sync_out & prev.
  - SET_EDGE[i] and CLR_EDGE[i] select the polarity per channel.
- Latency: an input level first sampled at clk edge k produces the q update at edge k+SYNC_STAGES.
  - q_chg is high for the cycle after that same edge (registered with q).
- Priority per channel per cycle: clear > set > toggle.
  - clr_ev: q <= 0.
  - else set_ev: q <= 1.
  - else tgl_ev: q <= ~q.
  - else hold.
- q_chg[i] = 1 only when the new q differs from the old. Set while q = 1 produces no strobe; toggle always strobes.
- Conflict: clr_ev and set_ev in the same cycle sets conflict[i]; clear still wins.
  - conflict_clr[i] clears the flag on the next edge.
  - Simultaneous new conflict and conflict_clr: flag stays 1 (set wins).
- Input pulses shorter than one clk period may be lost. This is documented, not flagged.
- rst mid-operation overrides everything in that cycle, including pending edges in the pipeline.
- Channels are fully independent; no cross-channel state.

Optional Feature:
- Macro MIOC_FLOP_CONFLICT_EN.
- Defined: conflict register, set/clear logic and conflict_clr are implemented as described above.
- Undefined: conflict is tied to 0, conflict_clr is ignored, and no conflict flops are synthesised. Ports remain present for a uniform interface; all other behaviour is identical.

Decomposition:
- Package mioc_flop_pkg holds:
  - Localparams EDGE_RISE = 1'b0 and EDGE_FALL = 1'b1.
  - SYNC_STAGES legal bounds (min 2, max 4) used in elaboration checks.
  - Typedef of the per-channel event struct {clr, set, tgl}.
- One sub-module, mioc_edge_sync: one-bit synchroniser, prev register, rising/falling detect, arm-mask input.
  - Parameters: STAGES, EDGE.
  - Instantiated 3*CHANNELS times by generate.

Test Plan:
- Reset with Q_INIT=4'b0101: q=0101, qbar=1010, q_chg=0, conflict=0. Toggle all raw inputs during and 1 cycle after reset → q unchanged, no q_chg during the arming window.
- SYNC_STAGES=2, set_in[0] rises before edge k → q[0]=1 after edge k+2, q_chg[0]=1 for exactly one cycle. Repeat set → q unchanged, q_chg stays 0.
- CLR_EDGE[1]=1, clr_in[1] falls while q[1]=1 → q[1]=0 after 2 edges. clr_in[1] rising → no change.
- Same-edge set_in[2] and clr_in[2] rising → q[2]=0 and conflict[2]=1 with MIOC_FLOP_CONFLICT_EN. Pulse conflict_clr[2] → 0 next cycle. Without the macro, conflict stays 0.
- tgl_in[3] three rising edges spaced 4 cycles apart from q=0 → q[3] sequence 1, 0, 1 with three q_chg pulses. Toggle coincident with set → q=1.
- Assert rst for one cycle while a set edge is mid-pipeline → q returns to Q_INIT and the pending set is discarded.
